// File: rtl/serial_word_shifter.sv
// Parallel-to-serial word shifter, MSB first, contiguous across back-to-back words.
// Define SER_PARITY_EN to append one even-parity bit to every frame.
module serial_word_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sd,
    output logic             sd_valid,
    output logic             sd_last,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             parity, parity_nxt;
    logic             sd_nxt, sd_valid_nxt, sd_last_nxt;
    logic             accept;

    // Ready is a pure decode of the state register, held low during reset.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE:   in_ready = 1'b1;
`ifdef SER_PARITY_EN
                S_SHIFT:  in_ready = 1'b0;
                S_PARITY: in_ready = 1'b1;
`else
                S_SHIFT:  in_ready = (cnt == CNT_LAST);
`endif
                default:  in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_nxt    = state;
        shift_nxt    = shift_reg;
        cnt_nxt      = cnt;
        parity_nxt   = parity;
        sd_nxt       = 1'b0;
        sd_valid_nxt = 1'b0;
        sd_last_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
            end
            S_SHIFT: begin
                if (cnt != CNT_LAST) begin
                    // shift_reg already excludes the bit currently on sd
                    sd_nxt       = shift_reg[WIDTH-1];
                    shift_nxt    = {shift_reg[WIDTH-2:0], 1'b0};
                    cnt_nxt      = cnt + 1'b1;
                    sd_valid_nxt = 1'b1;
`ifdef SER_PARITY_EN
                    sd_last_nxt  = 1'b0;
`else
                    sd_last_nxt  = (cnt == CNT_PEN);
`endif
                end else begin
                    cnt_nxt   = '0;
                    shift_nxt = '0;
`ifdef SER_PARITY_EN
                    state_nxt    = S_PARITY;
                    sd_nxt       = parity;
                    sd_valid_nxt = 1'b1;
                    sd_last_nxt  = 1'b1;
`else
                    state_nxt    = S_IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
`endif
            default: begin
                state_nxt  = S_IDLE;
                shift_nxt  = '0;
                cnt_nxt    = '0;
                parity_nxt = 1'b0;
            end
        endcase

        // A new word overrides whatever the current state would do next.
        if (accept) begin
            state_nxt    = S_SHIFT;
            sd_nxt       = in_data[WIDTH-1];
            shift_nxt    = {in_data[WIDTH-2:0], 1'b0};
            cnt_nxt      = '0;
            parity_nxt   = ^in_data;
            sd_valid_nxt = 1'b1;
            sd_last_nxt  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            parity    <= 1'b0;
            sd        <= 1'b0;
            sd_valid  <= 1'b0;
            sd_last   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            cnt       <= cnt_nxt;
            parity    <= parity_nxt;
            sd        <= sd_nxt;
            sd_valid  <= sd_valid_nxt;
            sd_last   <= sd_last_nxt;
        end
    end

    assign busy = sd_valid;

endmodule
